// File: rtl/lamp_sequence_monitor.sv
// Safety checker between the traffic-light FSM and the lamp drivers.
// Forwards legal lamp vectors one cycle late; latches a fault code and flashes red on any violation.
module lamp_sequence_monitor #(
  parameter int MIN_GREEN  = 4,
  parameter int MIN_YELLOW = 2,
  parameter int MIN_RED    = 4,
  parameter int MAX_DWELL  = 64,
  parameter int FLASH_HALF = 4,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] lights_in,
  input  logic       fault_clr,
  output logic [2:0] lamp_out,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int FL_W = $clog2(2*FLASH_HALF + 1);
  localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001, OFF = 3'b000;

  typedef enum logic [1:0] {INIT, TRACK, FAULT} state_t;

  state_t            state, nxt_state;
  logic [CNT_W-1:0]  dwell, nxt_dwell, min_cur;
  logic [FL_W-1:0]   flash, nxt_flash;
  logic [2:0]        nxt_lamp;
  logic              nxt_fault;
  logic [1:0]        nxt_code, viol;
  logic              one_hot, changed, pair_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      lamp_out   <= RED;
      fault      <= 1'b0;
      fault_code <= 2'b00;
      dwell      <= '0;
      flash      <= '0;
    end else begin
      state      <= nxt_state;
      lamp_out   <= nxt_lamp;
      fault      <= nxt_fault;
      fault_code <= nxt_code;
      dwell      <= nxt_dwell;
      flash      <= nxt_flash;
    end
  end

  // Violation classifier, highest priority first; 00 means the sample is legal.
  always_comb begin
    one_hot = (lights_in == RED) || (lights_in == YEL) || (lights_in == GRN);
    changed = (lights_in != lamp_out);
    pair_ok = (lamp_out == GRN && lights_in == YEL) ||
              (lamp_out == YEL && lights_in == RED) ||
              (lamp_out == RED && lights_in == GRN);
    min_cur = lamp_out[0] ? CNT_W'(MIN_GREEN) :
              lamp_out[1] ? CNT_W'(MIN_YELLOW) : CNT_W'(MIN_RED);
    viol = 2'b00;
    if (!one_hot)                                   viol = 2'b01;
    else if (changed && !pair_ok)                   viol = 2'b10;
    else if (changed && dwell < min_cur)            viol = 2'b11;
    else if (!changed && dwell == CNT_W'(MAX_DWELL)) viol = 2'b11;
  end

  always_comb begin
    nxt_state = state;
    case (state)
      INIT:    if (lights_in == RED) nxt_state = TRACK;
      TRACK:   if (viol != 2'b00)    nxt_state = FAULT;
      FAULT:   if (fault_clr)        nxt_state = INIT;
      default: nxt_state = INIT;
    endcase
  end

  always_comb begin
    nxt_lamp  = lamp_out;
    nxt_fault = fault;
    nxt_code  = fault_code;
    nxt_dwell = dwell;
    nxt_flash = '0;
    case (state)
      INIT: begin
        nxt_lamp = RED;
        if (lights_in == RED) nxt_dwell = CNT_W'(1);
      end
      TRACK: begin
        if (viol != 2'b00) begin
          nxt_lamp  = RED;
          nxt_fault = 1'b1;
          nxt_code  = viol;
        end else begin
          nxt_lamp  = lights_in;
          nxt_dwell = changed ? CNT_W'(1) : dwell + CNT_W'(1);
        end
      end
      FAULT: begin
        if (fault_clr) begin
          nxt_lamp  = RED;
          nxt_fault = 1'b0;
          nxt_code  = 2'b00;
          nxt_dwell = '0;
        end else begin
          // flash counts cycles already spent in FAULT; the entry cycle is count 0
          nxt_flash = (flash == FL_W'(2*FLASH_HALF - 1)) ? '0 : flash + FL_W'(1);
          nxt_lamp  = (nxt_flash < FL_W'(FLASH_HALF)) ? RED : OFF;
        end
      end
      default: nxt_lamp = RED;
    endcase
  end

endmodule

// File: tb/tb_lamp_sequence_monitor.sv
// Scoreboard bench: a behavioural model pushes expected outputs per edge, popped after the edge.
module tb_lamp_sequence_monitor;

  logic       clk = 1'b1;
  logic       rst_n = 1'b0;
  logic [2:0] lights_in = 3'b001;
  logic       fault_clr = 1'b0;
  logic [2:0] lamp_out;
  logic       fault;
  logic [1:0] fault_code;

  int n_chk = 0;
  int n_err = 0;

  logic [5:0] sb[$];

  // reference model state: 0=init 1=track 2=fault
  int         m_st;
  logic [2:0] m_lamp;
  int         m_dwell, m_flash;
  logic       m_fault;
  logic [1:0] m_code;

  lamp_sequence_monitor dut (
    .clk(clk), .rst_n(rst_n), .lights_in(lights_in), .fault_clr(fault_clr),
    .lamp_out(lamp_out), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_lamp = 3'b100; m_dwell = 0; m_flash = 0; m_fault = 1'b0; m_code = 2'b00;
  endtask

  task automatic m_edge(input logic [2:0] l, input logic clr);
    int mn;
    logic [1:0] v;
    if (m_st == 0) begin
      m_lamp = 3'b100;
      if (l == 3'b100) begin m_st = 1; m_dwell = 1; end
    end else if (m_st == 1) begin
      mn = (m_lamp == 3'b001) ? 4 : (m_lamp == 3'b010) ? 2 : 4;
      v = 2'b00;
      if ($countones(l) != 1) v = 2'b01;
      else if (l != m_lamp && !((m_lamp == 3'b001 && l == 3'b010) ||
               (m_lamp == 3'b010 && l == 3'b100) || (m_lamp == 3'b100 && l == 3'b001)))
        v = 2'b10;
      else if (l != m_lamp && m_dwell < mn) v = 2'b11;
      else if (l == m_lamp && m_dwell == 64) v = 2'b11;
      if (v != 2'b00) begin
        m_st = 2; m_fault = 1'b1; m_code = v; m_flash = 0; m_lamp = 3'b100;
      end else begin
        m_dwell = (l != m_lamp) ? 1 : m_dwell + 1;
        m_lamp = l;
      end
    end else begin
      if (clr) begin
        m_st = 0; m_fault = 1'b0; m_code = 2'b00; m_lamp = 3'b100; m_dwell = 0;
      end else begin
        m_flash = (m_flash + 1) % 8;
        m_lamp = (m_flash < 4) ? 3'b100 : 3'b000;
      end
    end
  endtask

  task automatic step(input logic [2:0] l, input logic clr = 1'b0);
    logic [5:0] e;
    lights_in = l;
    fault_clr = clr;
    m_edge(l, clr);
    sb.push_back({m_fault, m_code, m_lamp});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("out", {2'b00, fault, fault_code, lamp_out}, {2'b00, e});
  endtask

  task automatic steps(input logic [2:0] l, input int n);
    for (int i = 0; i < n; i++) step(l);
  endtask

  initial begin
    logic [2:0] flash_pat [12];
    m_reset();
    // reset with green on the input
    #14;
    chk("rst_lamp", {5'd0, lamp_out}, 8'h04);
    chk("rst_fault", {7'd0, fault}, 8'h00);
    chk("rst_code", {6'd0, fault_code}, 8'h00);
    #1 rst_n = 1'b1;
    steps(3'b001, 2);
    chk("init_hold", {5'd0, lamp_out}, 8'h04);
    step(3'b100);

    // legal cycle, 5 repetitions
    for (int r = 0; r < 5; r++) begin
      steps(3'b100, r == 0 ? 3 : 4);
      steps(3'b001, 4);
      steps(3'b010, 2);
    end
    chk("legal_nofault", {7'd0, fault}, 8'h00);

    // illegal encoding mid-green, then the flash pattern
    steps(3'b100, 4);
    steps(3'b001, 2);
    step(3'b110);
    chk("enc_code", {6'd0, fault_code}, 8'h01);
    chk("enc_fault", {7'd0, fault}, 8'h01);
    for (int i = 0; i < 12; i++) flash_pat[i] = ((i / 4) % 2 == 0) ? 3'b100 : 3'b000;
    for (int i = 1; i < 12; i++) begin
      step(3'($urandom_range(0, 7)));
      chk("flash", {5'd0, lamp_out}, {5'd0, flash_pat[i]});
    end
    step(3'b001, 1'b1);
    chk("clr_code", {6'd0, fault_code}, 8'h00);
    chk("clr_lamp", {5'd0, lamp_out}, 8'h04);

    // illegal G->R transition
    step(3'b100);
    steps(3'b100, 3);
    steps(3'b001, 4);
    step(3'b100);
    chk("trans_code", {6'd0, fault_code}, 8'h02);
    step(3'b000, 1'b1);

    // green too short
    steps(3'b100, 4);
    steps(3'b001, 2);
    step(3'b010);
    chk("short_code", {6'd0, fault_code}, 8'h03);
    step(3'b100, 1'b1);

    // red held too long: 64 samples are fine, the 65th faults
    steps(3'b100, 64);
    chk("dwell64", {7'd0, fault}, 8'h00);
    step(3'b100);
    chk("dwell65", {6'd0, fault, fault_code}, 8'h07);
    step(3'b100, 1'b1);
    steps(3'b100, 4);
    steps(3'b001, 3);
    chk("resume_fwd", {5'd0, lamp_out}, 8'h01);

    // async reset during the flash-off phase
    step(3'b000);
    steps(3'b010, 5);
    chk("flash_off", {5'd0, lamp_out}, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("async_lamp", {5'd0, lamp_out}, 8'h04);
    chk("async_fault", {7'd0, fault}, 8'h00);
    m_reset();
    #1 rst_n = 1'b1;
    steps(3'b010, 2);
    step(3'b100);
    step(3'b100);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
